// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the divider: FSM encoding, ALU codes for DIV/DIVU, default width.
package cpu_defs;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_e;

  // The datapath decodes these into start/signed_div.
  localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

  typedef struct packed {
    logic qNeg;
    logic rNeg;
    logic divZero;
  } divFlags_t;

endpackage

// File: rtl/div_unit_if.sv
// Divider request/response bundle between the execute-stage datapath and the divider.
interface div_unit_if import cpu_defs::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               annul;
  logic               stall_req;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_req, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_req, ready, result
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);
  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, divisor};

  // On success the difference is below the divisor, so it fits back in WIDTH bits.
  always_comb begin
    remNext = shifted[WIDTH-1:0];
    quoNext = {quo[WIDTH-2:0], 1'b0};
    if (fits) begin
      remNext = WIDTH'(shifted - {1'b0, divisor});
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; result = {hi = remainder, lo = quotient}.
module div_unit import cpu_defs::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave io
);
  localparam int CW = $clog2(WIDTH);

  divState_e          state, stateNext;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   remR, quoR, divR, aOrig;
  logic [WIDTH-1:0]   remN, quoN;
  divFlags_t          flags;
  logic [2*WIDTH-1:0] resR;

  logic               accept, lastIter;
  logic               loadOp, stepEn, loadRes;
  logic [WIDTH:0]     aExt, bExt;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign accept   = io.start & ~io.annul;
  assign lastIter = cnt == CW'(WIDTH-1);

  // Sign-extend by one bit so the magnitude of the most negative operand is exact.
  assign aExt = {io.signed_div & io.a[WIDTH-1], io.a};
  assign bExt = {io.signed_div & io.b[WIDTH-1], io.b};
  assign aMag = aExt[WIDTH] ? WIDTH'(-aExt) : io.a;
  assign bMag = bExt[WIDTH] ? WIDTH'(-bExt) : io.b;

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (remR),
    .quo     (quoR),
    .divisor (divR),
    .remNext (remN),
    .quoNext (quoN)
  );

  assign quoFix = flags.qNeg ? -quoN : quoN;
  assign remFix = flags.rNeg ? -remN : remN;

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      DIV_IDLE: if (accept) stateNext = DIV_BUSY;
      DIV_BUSY: begin
        if (io.annul)    stateNext = DIV_IDLE;
        else if (lastIter) stateNext = DIV_DONE;
      end
      DIV_DONE: stateNext = DIV_IDLE;
      default:  stateNext = DIV_IDLE;
    endcase
  end

  always_comb begin
    io.stall_req = 1'b0;
    io.ready     = 1'b0;
    loadOp       = 1'b0;
    stepEn       = 1'b0;
    loadRes      = 1'b0;
    case (state)
      DIV_IDLE: begin
        io.stall_req = accept;
        loadOp       = accept;
      end
      DIV_BUSY: begin
        io.stall_req = 1'b1;
        stepEn       = ~io.annul;
        loadRes      = ~io.annul & lastIter;
      end
      DIV_DONE: io.ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      remR  <= '0;
      quoR  <= '0;
      divR  <= '0;
      aOrig <= '0;
      flags <= '0;
      resR  <= '0;
    end else begin
      if (loadOp) begin
        cnt           <= '0;
        remR          <= '0;
        quoR          <= aMag;
        divR          <= bMag;
        aOrig         <= io.a;
        flags.qNeg    <= (io.a[WIDTH-1] ^ io.b[WIDTH-1]) & io.signed_div;
        flags.rNeg    <= io.a[WIDTH-1] & io.signed_div;
        flags.divZero <= io.b == '0;
      end else if (stepEn) begin
        cnt  <= cnt + 1'b1;
        remR <= remN;
        quoR <= quoN;
      end
      // Result is captured on the edge into DONE so it is visible with ready.
      if (loadRes) begin
        if (flags.divZero) resR <= {aOrig, {WIDTH{1'b1}}};
        else               resR <= {remFix, quoFix};
      end
    end
  end

  assign io.result = resR;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard-driven bench for div_unit: latency, stall/ready timing, signs, div-by-zero, annul, reset.
module tb_div_unit;
  import cpu_defs::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(bus));

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb[$];
  logic [63:0] lastRes = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic sg);
    longint      sa, sbv;
    logic [31:0] q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = 32'(sa / sbv);
      r   = 32'(sa % sbv);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issues one divide at the current cycle (cycle 0) and runs through cycle 33.
  task automatic divOp(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [63:0] exp, input string nm);
    logic [63:0] e;
    bus.a = a; bus.b = b; bus.signed_div = sg; bus.start = 1'b1;
    sb.push_back(exp);
    for (int cyc = 0; cyc <= 33; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.stall_req !== (cyc <= 32)) begin
        bad++;
        $display("FAIL %s stall cyc=%0d got=%b want=%b", nm, cyc, bus.stall_req, (cyc <= 32));
      end
      total++;
      if (bus.ready !== (cyc == 33)) begin
        bad++;
        $display("FAIL %s ready cyc=%0d got=%b want=%b", nm, cyc, bus.ready, (cyc == 33));
      end
      if (bus.ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected ready, scoreboard empty", nm);
        end else begin
          e = sb.pop_front();
          if (bus.result !== e) begin
            bad++;
            $display("FAIL %s result got=%h want=%h", nm, bus.result, e);
          end
          lastRes = e;
        end
      end
      tick();
      if (cyc == 0) bus.start = 1'b0;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s no ready within budget, pending=%0d", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.annul = 0; bus.signed_div = 0; bus.a = '0; bus.b = '0;
    tick(); tick();
    @(negedge clk);
    total++;
    if (bus.ready !== 1'b0 || bus.stall_req !== 1'b0 || bus.result !== 64'd0) begin
      bad++;
      $display("FAIL reset got ready=%b stall=%b result=%h want 0/0/0", bus.ready, bus.stall_req, bus.result);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    divOp(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "udiv_100_7");
  endtask

  task automatic test_signed();
    divOp(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "sdiv_m7_2");
    divOp(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, "sdiv_7_m2");
  endtask

  task automatic test_overflow();
    divOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, "sdiv_min_m1");
    divOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, "udiv_min_max");
  endtask

  task automatic test_div_zero();
    divOp(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, "udiv_zero");
    divOp(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, "sdiv_zero");
    divOp(32'hF000_0001, 32'd0, 1'b1, {32'hF000_0001, 32'hFFFF_FFFF}, "sdiv_zero_neg");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        sg;
    for (int i = 0; i < 6; i++) begin
      a  = $urandom;
      b  = (i < 3) ? $urandom_range(1, 1000) : $urandom;
      sg = i[0];
      divOp(a, b, sg, model(a, b, sg), "rand");
    end
  endtask

  task automatic test_annul();
    bus.a = 32'h1234_5678; bus.b = 32'd3; bus.signed_div = 0; bus.start = 1'b1;
    for (int cyc = 0; cyc <= 11; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.stall_req !== (cyc <= 10)) begin
        bad++;
        $display("FAIL annul stall cyc=%0d got=%b want=%b", cyc, bus.stall_req, (cyc <= 10));
      end
      total++;
      if (bus.ready !== 1'b0 || bus.result !== lastRes) begin
        bad++;
        $display("FAIL annul hold cyc=%0d ready=%b result=%h want 0/%h", cyc, bus.ready, bus.result, lastRes);
      end
      tick();
      if (cyc == 0)  bus.start = 1'b0;
      if (cyc == 9)  bus.annul = 1'b1;
      if (cyc == 10) bus.annul = 1'b0;
    end
    divOp(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "after_annul");
  endtask

  task automatic test_idle_annul();
    bus.a = 32'd50; bus.b = 32'd5; bus.start = 1'b1; bus.annul = 1'b1;
    @(negedge clk);
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_annul stall got=%b want=0", bus.stall_req);
    end
    tick();
    bus.start = 1'b0; bus.annul = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.stall_req !== 1'b0 || bus.ready !== 1'b0) begin
        bad++;
        $display("FAIL idle_annul cyc=%0d stall=%b ready=%b want 0/0", cyc, bus.stall_req, bus.ready);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    bus.a = 32'd1000; bus.b = 32'd9; bus.signed_div = 0; bus.start = 1'b1;
    for (int cyc = 0; cyc <= 4; cyc++) begin
      tick();
      if (cyc == 0) bus.start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ready !== 1'b0 || bus.stall_req !== 1'b0 || bus.result !== 64'd0) begin
      bad++;
      $display("FAIL mid_reset ready=%b stall=%b result=%h want 0/0/0", bus.ready, bus.stall_req, bus.result);
    end
    lastRes = '0;
    // Nothing of the killed divide may surface later.
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      @(negedge clk);
      total++;
      if (bus.ready !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset stray ready cyc=%0d got=%b want=0", cyc, bus.ready);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic        rdyWant;
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 0; bus.start = 1'b1;
    sb.push_back({32'h0000_0002, 32'h0000_000E});
    for (int cyc = 0; cyc <= 67; cyc++) begin
      rdyWant = (cyc == 33) || (cyc == 67);
      @(negedge clk);
      total++;
      if (bus.ready !== rdyWant || bus.stall_req !== !rdyWant) begin
        bad++;
        $display("FAIL b2b cyc=%0d ready=%b stall=%b want %b/%b", cyc, bus.ready, bus.stall_req, rdyWant, !rdyWant);
      end
      if (bus.ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b unexpected ready cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.result !== e) begin
            bad++;
            $display("FAIL b2b result cyc=%0d got=%h want=%h", cyc, bus.result, e);
          end
        end
      end
      tick();
      if (cyc == 33) begin
        bus.a = 32'hFFFF_FF9C; bus.b = 32'd7; bus.signed_div = 1'b1;
        sb.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
      end
      if (cyc == 34) bus.start = 1'b0;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL b2b missing ready, pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_random();
    test_annul();
    test_idle_annul();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
